// File: rtl/mdom_wvb_hdr_fifo_fan_out.sv
// ---------------------------------------------------------------------------
// mdom_wvb_hdr_fifo_fan_out
//
// Buffers packed waveform header bundles from the waveform-buffer writer in a
// small FIFO. It presents the oldest header as registered, individually named
// fields on a valid/ready interface. The waveform length is derived from the
// start/stop addresses of the same entry and registered alongside the fields.
// The block also tracks the FIFO fill level and counts headers dropped on
// overflow.
//
// Bundle packing, LSB first:
//   evt_ltc(49) start_addr(ADDR_W) stop_addr(ADDR_W) trig_src(2) cnst_run(1)
//   pre_conf(5) sync_rdy(1) bsum(19) bsum_len_sel(3) bsum_valid(1)
//   local_coinc(1)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hdr_in, hdr_wr  packed header bundle and its single-cycle push strobe
//   hdr_rdy         downstream ready
//   hdr_valid       output field registers hold a valid header
//   evt_ltc..local_coinc  unpacked header fields (registered)
//   wvb_len         ((stop-start) mod 2^ADDR_W) + 1, registered with fields
//   fifo_cnt        entries held in FIFO storage (output register excluded)
//   ovfl, drop_cnt  sticky overflow flag and saturating drop counter
//   clr_ovfl        clears ovfl and drop_cnt
// ---------------------------------------------------------------------------
module mdom_wvb_hdr_fifo_fan_out #(
  parameter  int ADDR_W     = 12,
  parameter  int DEPTH_LOG2 = 3,
  localparam int BUNDLE_W   = 82 + 2*ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUNDLE_W-1:0]   hdr_in,
  input  logic                  hdr_wr,
  input  logic                  hdr_rdy,
  output logic                  hdr_valid,
  output logic [48:0]           evt_ltc,
  output logic [ADDR_W-1:0]     start_addr,
  output logic [ADDR_W-1:0]     stop_addr,
  output logic [1:0]            trig_src,
  output logic                  cnst_run,
  output logic [4:0]            pre_conf,
  output logic                  sync_rdy,
  output logic [18:0]           bsum,
  output logic [2:0]            bsum_len_sel,
  output logic                  bsum_valid,
  output logic                  local_coinc,
  output logic [ADDR_W:0]       wvb_len,
  output logic [DEPTH_LOG2:0]   fifo_cnt,
  output logic                  ovfl,
  output logic [15:0]           drop_cnt,
  input  logic                  clr_ovfl
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  // Field offsets within the bundle
  localparam int OFF_START = 49;
  localparam int OFF_STOP  = OFF_START + ADDR_W;
  localparam int OFF_TRIG  = OFF_STOP + ADDR_W;
  localparam int OFF_CNST  = OFF_TRIG + 2;
  localparam int OFF_PRE   = OFF_CNST + 1;
  localparam int OFF_SYNC  = OFF_PRE + 5;
  localparam int OFF_BSUM  = OFF_SYNC + 1;
  localparam int OFF_BLS   = OFF_BSUM + 19;
  localparam int OFF_BV    = OFF_BLS + 3;
  localparam int OFF_LC    = OFF_BV + 1;

  logic [BUNDLE_W-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_cnt;
  logic                  r_valid;
  logic [BUNDLE_W-1:0]   r_hdr;
  logic [ADDR_W:0]       r_len;
  logic                  r_ovfl;
  logic [15:0]           r_drop_cnt;

  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_load;
  logic [BUNDLE_W-1:0]   w_head;
  logic [ADDR_W-1:0]     w_diff;
  logic [ADDR_W:0]       w_len;

  // Full is judged on the registered count, so a pop in the same cycle
  // cannot make room for a push.
  assign w_full = (r_cnt == FULL_CNT);
  assign w_push = hdr_wr && !w_full;
  assign w_drop = hdr_wr && w_full;
  assign w_load = (!r_valid || hdr_rdy) && (r_cnt != '0);

  // The output field register acts as the registered read port of the
  // storage array.
  assign w_head = r_mem[r_rd_ptr];

  // Modulo subtraction covers stop < start; +1 gives range 1..2^ADDR_W.
  assign w_diff = w_head[OFF_STOP +: ADDR_W] - w_head[OFF_START +: ADDR_W];
  assign w_len  = {1'b0, w_diff} + (ADDR_W+1)'(1);

  // Storage array: no reset, contents are only meaningful under r_cnt.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= hdr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_hdr      <= '0;
      r_len      <= '0;
      r_ovfl     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end

      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
        r_hdr    <= w_head;
        r_len    <= w_len;
        r_valid  <= 1'b1;
      end else if (r_valid && hdr_rdy) begin
        r_valid  <= 1'b0;
      end

      case ({w_push, w_load})
        2'b10:   r_cnt <= r_cnt + (DEPTH_LOG2+1)'(1);
        2'b01:   r_cnt <= r_cnt - (DEPTH_LOG2+1)'(1);
        default: r_cnt <= r_cnt;
      endcase

      // A drop coincident with a clear restarts the count at one.
      if (w_drop) begin
        r_ovfl <= 1'b1;
        if (clr_ovfl) begin
          r_drop_cnt <= 16'd1;
        end else if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end else if (clr_ovfl) begin
        r_ovfl     <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  assign hdr_valid    = r_valid;
  assign evt_ltc      = r_hdr[48:0];
  assign start_addr   = r_hdr[OFF_START +: ADDR_W];
  assign stop_addr    = r_hdr[OFF_STOP +: ADDR_W];
  assign trig_src     = r_hdr[OFF_TRIG +: 2];
  assign cnst_run     = r_hdr[OFF_CNST];
  assign pre_conf     = r_hdr[OFF_PRE +: 5];
  assign sync_rdy     = r_hdr[OFF_SYNC];
  assign bsum         = r_hdr[OFF_BSUM +: 19];
  assign bsum_len_sel = r_hdr[OFF_BLS +: 3];
  assign bsum_valid   = r_hdr[OFF_BV];
  assign local_coinc  = r_hdr[OFF_LC];
  assign wvb_len      = r_len;
  assign fifo_cnt     = r_cnt;
  assign ovfl         = r_ovfl;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_mdom_wvb_hdr_fifo_fan_out.sv
// ---------------------------------------------------------------------------
// tb_mdom_wvb_hdr_fifo_fan_out
//
// Directed bench for the header FIFO fan-out. Instance a uses the default
// parameters (ADDR_W=12, D=8), instance b uses ADDR_W=14, DEPTH_LOG2=2 and
// random push/ready traffic against a queue model.
// ---------------------------------------------------------------------------
module tb_mdom_wvb_hdr_fifo_fan_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance a: default parameters ----------------
  logic         rst, hdr_wr, hdr_rdy, clr_ovfl;
  logic [105:0] hdr_in;
  logic         hdr_valid, cnst_run, sync_rdy, bsum_valid, local_coinc, ovfl;
  logic [48:0]  evt_ltc;
  logic [11:0]  start_addr, stop_addr;
  logic [1:0]   trig_src;
  logic [4:0]   pre_conf;
  logic [18:0]  bsum;
  logic [2:0]   bsum_len_sel;
  logic [12:0]  wvb_len;
  logic [3:0]   fifo_cnt;
  logic [15:0]  drop_cnt;

  mdom_wvb_hdr_fifo_fan_out dut_a (
    .clk(clk), .rst(rst), .hdr_in(hdr_in), .hdr_wr(hdr_wr), .hdr_rdy(hdr_rdy),
    .hdr_valid(hdr_valid), .evt_ltc(evt_ltc), .start_addr(start_addr),
    .stop_addr(stop_addr), .trig_src(trig_src), .cnst_run(cnst_run),
    .pre_conf(pre_conf), .sync_rdy(sync_rdy), .bsum(bsum),
    .bsum_len_sel(bsum_len_sel), .bsum_valid(bsum_valid),
    .local_coinc(local_coinc), .wvb_len(wvb_len), .fifo_cnt(fifo_cnt),
    .ovfl(ovfl), .drop_cnt(drop_cnt), .clr_ovfl(clr_ovfl)
  );

  logic [105:0] a_bundle;
  assign a_bundle = {local_coinc, bsum_valid, bsum_len_sel, bsum, sync_rdy,
                     pre_conf, cnst_run, trig_src, stop_addr, start_addr, evt_ltc};

  // ---------------- instance b: ADDR_W=14, DEPTH_LOG2=2 ----------------
  logic         b_rst, b_wr, b_rdy, b_clr;
  logic [109:0] b_in;
  logic         b_valid, b_cnst, b_sync, b_bv, b_lc, b_ovfl;
  logic [48:0]  b_evt;
  logic [13:0]  b_start, b_stop;
  logic [1:0]   b_trig;
  logic [4:0]   b_pre;
  logic [18:0]  b_bsum;
  logic [2:0]   b_bls;
  logic [14:0]  b_len;
  logic [2:0]   b_cnt;
  logic [15:0]  b_drop;

  mdom_wvb_hdr_fifo_fan_out #(.ADDR_W(14), .DEPTH_LOG2(2)) dut_b (
    .clk(clk), .rst(b_rst), .hdr_in(b_in), .hdr_wr(b_wr), .hdr_rdy(b_rdy),
    .hdr_valid(b_valid), .evt_ltc(b_evt), .start_addr(b_start),
    .stop_addr(b_stop), .trig_src(b_trig), .cnst_run(b_cnst),
    .pre_conf(b_pre), .sync_rdy(b_sync), .bsum(b_bsum),
    .bsum_len_sel(b_bls), .bsum_valid(b_bv), .local_coinc(b_lc),
    .wvb_len(b_len), .fifo_cnt(b_cnt), .ovfl(b_ovfl), .drop_cnt(b_drop),
    .clr_ovfl(b_clr)
  );

  logic [109:0] b_bundle;
  assign b_bundle = {b_lc, b_bv, b_bls, b_bsum, b_sync, b_pre, b_cnst, b_trig,
                     b_stop, b_start, b_evt};

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Random 106-bit bundle with explicit evt/start/stop; lc forces bit 105.
  function automatic logic [105:0] mk_a(input logic [48:0] evt, input logic [11:0] st,
                                        input logic [11:0] sp, input logic lc);
    logic [127:0] t;
    logic [105:0] b;
    t = rnd128();
    b = t[105:0];
    b[48:0]   = evt;
    b[60:49]  = st;
    b[72:61]  = sp;
    b[105]    = lc;
    return b;
  endfunction

  typedef struct {
    logic [11:0] start;
    logic [11:0] stop;
    logic [48:0] evt;
    logic        lc;
    logic [12:0] exp_len;
  } vec_t;

  vec_t vecs[4];
  logic [105:0] h [10];
  logic [105:0] cur;
  logic [127:0] t128;

  // Model state for instance b
  logic [109:0] q[$];
  logic [109:0] m_out;
  logic         m_valid;

  initial begin
    vecs[0] = '{12'h010, 12'h01F, 49'h1_2345_6789_ABCD, 1'b1, 13'd16};
    vecs[1] = '{12'hFF0, 12'h00F, 49'h0_F0F0_0F0F_1234, 1'b0, 13'd32};
    vecs[2] = '{12'h100, 12'h0FF, 49'h1_FFFF_FFFF_FFFF, 1'b1, 13'd4096};
    vecs[3] = '{12'h7A5, 12'h7A5, 49'h0_0000_0000_0001, 1'b0, 13'd1};

    rst = 1'b1; hdr_wr = 1'b1; hdr_rdy = 1'b1; clr_ovfl = 1'b0;
    hdr_in = mk_a(49'h1, 12'h1, 12'h2, 1'b1);
    b_rst = 1'b1; b_wr = 1'b0; b_rdy = 1'b0; b_clr = 1'b0; b_in = '0;

    // ---- reset state (push during reset must be ignored) ----
    step(); step();
    chk("rst_valid",  128'(hdr_valid), 128'(0));
    chk("rst_fields", 128'(a_bundle), 128'(0));
    chk("rst_len",    128'(wvb_len), 128'(0));
    chk("rst_cnt",    128'(fifo_cnt), 128'(0));
    chk("rst_ovfl",   128'(ovfl), 128'(0));
    chk("rst_drop",   128'(drop_cnt), 128'(0));
    rst = 1'b0; hdr_wr = 1'b0;
    step();
    chk("rst_push_ignored_cnt",   128'(fifo_cnt), 128'(0));
    chk("rst_push_ignored_valid", 128'(hdr_valid), 128'(0));

    // ---- table: single header latency, field slices, wvb_len ----
    for (int i = 0; i < 4; i++) begin
      cur = mk_a(vecs[i].evt, vecs[i].start, vecs[i].stop, vecs[i].lc);
      hdr_in = cur; hdr_wr = 1'b1; hdr_rdy = 1'b1;
      step();
      chk("vec_push_cnt",    128'(fifo_cnt), 128'(1));
      chk("vec_push_valid",  128'(hdr_valid), 128'(0));
      hdr_wr = 1'b0;
      step();
      chk("vec_valid",  128'(hdr_valid), 128'(1));
      chk("vec_evt",    128'(evt_ltc), 128'(cur[48:0]));
      chk("vec_start",  128'(start_addr), 128'(cur[60:49]));
      chk("vec_stop",   128'(stop_addr), 128'(cur[72:61]));
      chk("vec_trig",   128'(trig_src), 128'(cur[74:73]));
      chk("vec_cnst",   128'(cnst_run), 128'(cur[75]));
      chk("vec_pre",    128'(pre_conf), 128'(cur[80:76]));
      chk("vec_sync",   128'(sync_rdy), 128'(cur[81]));
      chk("vec_bsum",   128'(bsum), 128'(cur[100:82]));
      chk("vec_bls",    128'(bsum_len_sel), 128'(cur[103:101]));
      chk("vec_bv",     128'(bsum_valid), 128'(cur[104]));
      chk("vec_lc",     128'(local_coinc), 128'(cur[105]));
      chk("vec_len",    128'(wvb_len), 128'(vecs[i].exp_len));
      chk("vec_cnt0",   128'(fifo_cnt), 128'(0));
      step();
      chk("vec_valid_drop", 128'(hdr_valid), 128'(0));
      $display("[TB] vec %0d start=%h stop=%h wvb_len=%0d", i, vecs[i].start, vecs[i].stop, wvb_len);
    end

    // ---- backpressure: 10 pushes into 1 + 8, one drop ----
    hdr_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      h[k] = mk_a(49'(k + 100), 12'(k), 12'(k + 3), k[0]);
      hdr_in = h[k]; hdr_wr = 1'b1;
      step();
      if (k >= 1) begin
        chk("bp_valid",  128'(hdr_valid), 128'(1));
        chk("bp_stable", 128'(a_bundle), 128'(h[0]));
      end
    end
    hdr_wr = 1'b0;
    chk("bp_cnt",  128'(fifo_cnt), 128'(8));
    chk("bp_ovfl", 128'(ovfl), 128'(1));
    chk("bp_drop", 128'(drop_cnt), 128'(1));
    step();
    chk("bp_hold", 128'(a_bundle), 128'(h[0]));
    hdr_rdy = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("drain_valid", 128'(hdr_valid), 128'(1));
      chk("drain_order", 128'(a_bundle), 128'(h[j]));
      chk("drain_cnt",   128'(fifo_cnt), 128'(8 - j));
      $display("[TB] drain %0d evt=%h cnt=%0d", j, evt_ltc, fifo_cnt);
    end
    step();
    chk("drain_end_valid", 128'(hdr_valid), 128'(0));

    // ---- full with simultaneous push and pop; clear vs drop ----
    clr_ovfl = 1'b1;
    step();
    clr_ovfl = 1'b0;
    chk("clr_ovfl", 128'(ovfl), 128'(0));
    chk("clr_drop", 128'(drop_cnt), 128'(0));
    hdr_rdy = 1'b0; hdr_wr = 1'b1;
    for (int k = 0; k < 9; k++) begin
      hdr_in = mk_a(49'(k + 200), 12'h0, 12'h0, 1'b0);
      step();
    end
    chk("full_cnt", 128'(fifo_cnt), 128'(8));
    hdr_rdy = 1'b1;
    step();
    chk("full_pop_cnt",  128'(fifo_cnt), 128'(7));
    chk("full_pop_drop", 128'(drop_cnt), 128'(1));
    chk("full_pop_ovfl", 128'(ovfl), 128'(1));
    hdr_rdy = 1'b0;
    step();
    chk("refill_cnt", 128'(fifo_cnt), 128'(8));
    step();
    chk("drop2", 128'(drop_cnt), 128'(2));
    clr_ovfl = 1'b1;
    step();
    chk("clr_with_drop_ovfl", 128'(ovfl), 128'(1));
    chk("clr_with_drop_cnt",  128'(drop_cnt), 128'(1));
    hdr_wr = 1'b0;
    step();
    clr_ovfl = 1'b0;
    chk("clr_alone_ovfl", 128'(ovfl), 128'(0));
    chk("clr_alone_cnt",  128'(drop_cnt), 128'(0));

    // ---- reset mid-operation ----
    rst = 1'b1;
    step();
    rst = 1'b0; hdr_wr = 1'b1; hdr_rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      hdr_in = mk_a(49'(k + 300), 12'h5, 12'h9, 1'b1);
      step();
    end
    chk("mid_cnt5",   128'(fifo_cnt), 128'(5));
    chk("mid_valid1", 128'(hdr_valid), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0; hdr_wr = 1'b0;
    chk("mid_rst_valid",  128'(hdr_valid), 128'(0));
    chk("mid_rst_fields", 128'(a_bundle), 128'(0));
    chk("mid_rst_len",    128'(wvb_len), 128'(0));
    chk("mid_rst_cnt",    128'(fifo_cnt), 128'(0));
    cur = mk_a(49'h0_ABCD_EF01_2345, 12'h020, 12'h02F, 1'b1);
    hdr_in = cur; hdr_wr = 1'b1; hdr_rdy = 1'b1;
    step();
    hdr_wr = 1'b0;
    step();
    chk("post_rst_valid",  128'(hdr_valid), 128'(1));
    chk("post_rst_fields", 128'(a_bundle), 128'(cur));
    chk("post_rst_len",    128'(wvb_len), 128'(16));
    step();
    chk("post_rst_no_stale_valid", 128'(hdr_valid), 128'(0));
    chk("post_rst_no_stale_cnt",   128'(fifo_cnt), 128'(0));

    // ---- instance b: random traffic vs queue model ----
    step();
    b_rst = 1'b0;
    q.delete();
    m_valid = 1'b0;
    m_out = '0;
    for (int c = 0; c < 400; c++) begin
      logic ld, ps;
      logic [13:0] d;
      t128  = rnd128();
      b_in  = t128[109:0];
      b_wr  = ($urandom_range(0, 99) < 60);
      b_rdy = ($urandom_range(0, 99) < 50);
      ld = (!m_valid || b_rdy) && (q.size() > 0);
      ps = b_wr && (q.size() < 4);
      if (ld) begin
        m_out = q.pop_front();
        m_valid = 1'b1;
      end else if (m_valid && b_rdy) begin
        m_valid = 1'b0;
      end
      if (ps) q.push_back(b_in);
      step();
      chk("b_valid", 128'(b_valid), 128'(m_valid));
      chk("b_cnt",   128'(b_cnt), 128'(q.size()));
      if (m_valid) begin
        d = m_out[76:63] - m_out[62:49];
        chk("b_fields", 128'(b_bundle), 128'(m_out));
        chk("b_lc109",  128'(b_lc), 128'(m_out[109]));
        chk("b_len",    128'(b_len), 128'({1'b0, d} + 15'd1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
